// File: rtl/sha3_pad_feeder_if.sv
// sha3_pad_feeder_if: message-input stream and core-side lane bus of the
// SHA3 pad feeder. "master" is the upstream/core side, "slave" the feeder.
// Optional macro SHA3_PAD_SHAKE_EN adds the in_shake domain select.
interface sha3_pad_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_bytes;
  logic        in_last;
`ifdef SHA3_PAD_SHAKE_EN
  logic        in_shake;
`endif
  logic        core_ready;
  logic        out_start;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last_block;

  modport master (
    output in_valid, in_data, in_bytes, in_last,
`ifdef SHA3_PAD_SHAKE_EN
    output in_shake,
`endif
    output core_ready,
    input  in_ready, out_start, out_valid, out_data, out_last_block
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last,
`ifdef SHA3_PAD_SHAKE_EN
    input  in_shake,
`endif
    input  core_ready,
    output in_ready, out_start, out_valid, out_data, out_last_block
  );
endinterface

// File: rtl/sha3_pad_feeder.sv
// sha3_pad_feeder: packs a little-endian 64-bit word stream into SHA-3 rate
// blocks, applies pad10*1 with the domain byte, and replays each block to the
// core as RATE_LANES back-to-back lanes once the core reports ready.
// Optional macro SHA3_PAD_SHAKE_EN: in_shake selects domain byte 0x1F.
module sha3_pad_feeder #(
  parameter int RATE_LANES = 17
) (
  input  logic              clk,
  input  logic              rst,
  sha3_pad_feeder_if.slave  bus
);

  localparam int              IW       = $clog2(RATE_LANES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(RATE_LANES - 1);
  localparam logic [63:0]     END_BIT  = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_WAIT_CORE,
    ST_START,
    ST_EMIT,
    ST_PADBLK
  } state_t;

  state_t        state_q, state_nxt;
  logic [63:0]   lanes_q [RATE_LANES];
  logic [IW-1:0] idx_q;          // fill write pointer, then lane on the output
  logic          first_q;        // next block emitted is the message's first
  logic          final_q;        // buffered block ends the message
  logic          pad_pending_q;  // a pure padding block must follow
  logic          shake_q;

  logic          in_ready_q, out_start_q, out_valid_q, out_last_q;
  logic [63:0]   out_data_q;
  logic          in_ready_nxt, out_start_nxt, out_valid_nxt, out_last_nxt;
  logic [63:0]   out_data_nxt;

  logic          accept, short_last, pad_full_end, shake_in, shake_cur;
  logic [7:0]    dom;
  logic [63:0]   dom_lane, byte_mask, last_lane;
  logic [IW-1:0] emit_sel;
  logic [63:0]   tail_lane [RATE_LANES];

`ifdef SHA3_PAD_SHAKE_EN
  assign shake_in = bus.in_shake;
`else
  assign shake_in = 1'b0;
`endif

  // Word-level decode of the input beat and the domain byte in force.
  assign accept       = in_ready_q & bus.in_valid;
  assign short_last   = bus.in_last && (bus.in_bytes < 4'd8);
  assign pad_full_end = bus.in_last && !short_last && (idx_q == LAST_IDX);
  assign shake_cur    = (first_q && idx_q == '0) ? shake_in : shake_q;
  assign dom          = shake_cur ? 8'h1F : 8'h06;
  assign dom_lane     = {56'd0, dom};
  assign byte_mask    = ~(64'hFFFF_FFFF_FFFF_FFFF << {bus.in_bytes[2:0], 3'b000});
  assign last_lane    = short_last
                      ? ((bus.in_data & byte_mask) | (dom_lane << {bus.in_bytes[2:0], 3'b000}))
                      : bus.in_data;

  // Whole-buffer image after writing the final message word with padding.
  always_comb begin
    for (int i = 0; i < RATE_LANES; i++) begin
      tail_lane[i] = lanes_q[i];
      if (IW'(i) == idx_q)
        tail_lane[i] = last_lane;
      else if (IW'(i) > idx_q)
        tail_lane[i] = (!short_last && IW'(i) == idx_q + IW'(1)) ? dom_lane : 64'd0;
      if (i == RATE_LANES - 1 && !pad_full_end)
        tail_lane[i] = tail_lane[i] | END_BIT;
    end
  end

  // Next state and next registered outputs.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_FILL:      if (accept && (bus.in_last || idx_q == LAST_IDX)) state_nxt = ST_WAIT_CORE;
      ST_WAIT_CORE: if (bus.core_ready) state_nxt = first_q ? ST_START : ST_EMIT;
      ST_START:     state_nxt = ST_EMIT;
      ST_EMIT:      if (idx_q == LAST_IDX) state_nxt = pad_pending_q ? ST_PADBLK : ST_FILL;
      ST_PADBLK:    state_nxt = ST_WAIT_CORE;
      default:      state_nxt = ST_FILL;
    endcase

    emit_sel      = (state_q == ST_EMIT) ? idx_q + IW'(1) : '0;
    in_ready_nxt  = (state_nxt == ST_FILL);
    out_start_nxt = (state_nxt == ST_START);
    out_valid_nxt = (state_nxt == ST_EMIT);
    out_data_nxt  = out_valid_nxt ? lanes_q[emit_sel] : 64'd0;
    out_last_nxt  = out_valid_nxt && final_q && (emit_sel == LAST_IDX);
  end

  // State register and registered handshake/output flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      in_ready_q  <= 1'b0;
      out_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 64'd0;
    end else begin
      state_q     <= state_nxt;
      in_ready_q  <= in_ready_nxt;
      out_start_q <= out_start_nxt;
      out_valid_q <= out_valid_nxt;
      out_last_q  <= out_last_nxt;
      out_data_q  <= out_data_nxt;
    end
  end

  // Block buffer, lane pointer and per-message flags.
  // NOTE: the lane buffer is reset because a partial message must never leak into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RATE_LANES; i++) lanes_q[i] <= 64'd0;
      idx_q         <= '0;
      first_q       <= 1'b1;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
      shake_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FILL: if (accept) begin
          if (first_q && idx_q == '0) shake_q <= shake_in;
          if (bus.in_last) begin
            for (int i = 0; i < RATE_LANES; i++) lanes_q[i] <= tail_lane[i];
            final_q       <= !pad_full_end;
            pad_pending_q <= pad_full_end;
          end else begin
            lanes_q[idx_q] <= bus.in_data;
            final_q        <= 1'b0;
            if (idx_q != LAST_IDX) idx_q <= idx_q + IW'(1);
          end
        end
        ST_WAIT_CORE: if (bus.core_ready) idx_q <= '0;
        ST_START: begin
          first_q <= 1'b0;
          idx_q   <= '0;
        end
        ST_EMIT: begin
          if (idx_q == LAST_IDX) begin
            for (int i = 0; i < RATE_LANES; i++) lanes_q[i] <= 64'd0;
            idx_q <= '0;
            if (final_q) first_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_PADBLK: begin
          lanes_q[0]            <= dom_lane;
          lanes_q[RATE_LANES-1] <= END_BIT;
          final_q               <= 1'b1;
          pad_pending_q         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_start      = out_start_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_last_block = out_last_q;

endmodule

// File: tb/tb_sha3_pad_feeder.sv
// tb_sha3_pad_feeder: directed vectors with hand-computed lanes for the
// SHA3 pad feeder (default build, RATE_LANES = 17).
`timescale 1ns/1ps
module tb_sha3_pad_feeder;

  localparam int          R       = 17;
  localparam logic [63:0] END_BIT = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha3_pad_feeder_if bus ();
  sha3_pad_feeder #(.RATE_LANES(R)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [63:0] msg [$];
  logic [63:0] cap_data [$];
  logic        cap_lastb [$];
  int          runs [$];
  int          run_len    = 0;
  int          start_cnt  = 0;
  int          idle_dirty = 0;
  int          acc_edge   = 0;
  int          start_edge = 0;
  int          lane0_edge = 0;
  logic [63:0] exp_lanes [R];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5C3_0000_0000_0000 | (64'(i) * 64'h0000_0101_0101_0101);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: samples on the falling edge, before the stimulus process.
  initial forever begin
    @(negedge clk);
    if (bus.out_start) begin
      start_cnt++;
      start_edge = cyc + 1;
    end
    if (bus.out_valid) begin
      if (cap_data.size() == 0) lane0_edge = cyc + 1;
      cap_data.push_back(bus.out_data);
      cap_lastb.push_back(bus.out_last_block);
      run_len++;
    end else begin
      if (bus.out_data != 64'd0 || bus.out_last_block) idle_dirty++;
      if (run_len != 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_lastb.delete();
    runs.delete();
    start_cnt  = 0;
    idle_dirty = 0;
  endtask

  task automatic send_msg(input int last_bytes, input logic [3:0] mid_bytes);
    int guard;
    for (int i = 0; i < msg.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_last  = (i == msg.size() - 1);
      bus.in_bytes = bus.in_last ? 4'(last_bytes) : mid_bytes;
      guard = 0;
      while (!bus.in_ready && guard < 300) begin
        tick();
        guard++;
      end
      if (guard >= 300) begin
        check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        break;
      end
      if (bus.in_last) acc_edge = cyc + 1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_lanes(input string tag, input int n);
    int g;
    g = 0;
    while (cap_data.size() < n && g < 400) begin
      tick();
      g++;
    end
    check({tag, "_lane_count"}, 64'(cap_data.size()), 64'(n));
    repeat (3) tick();
  endtask

  task automatic check_block(input string tag, input int base, input logic [R-1:0] exp_lb);
    logic [R-1:0] got_lb;
    got_lb = '0;
    for (int i = 0; i < R; i++) begin
      check($sformatf("%s_lane%0d", tag, i), cap_data[base+i], exp_lanes[i]);
      got_lb[i] = cap_lastb[base+i];
    end
    check({tag, "_last_block_map"}, 64'(got_lb), 64'(exp_lb));
  endtask

  task automatic set_pad_block();
    for (int i = 0; i < R; i++) exp_lanes[i] = 64'd0;
    exp_lanes[0]   = 64'h06;
    exp_lanes[R-1] = END_BIT;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = 64'd0;
    bus.in_bytes   = 4'd0;
    bus.in_last    = 1'b0;
    bus.core_ready = 1'b1;
`ifdef SHA3_PAD_SHAKE_EN
    bus.in_shake   = 1'b0;
`endif

    // Reset state.
    repeat (3) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_start", 64'(bus.out_start), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    clear_cap();

    // Empty message.
    msg = {64'd0};
    send_msg(0, 4'd8);
    wait_lanes("empty", R);
    set_pad_block();
    check_block("empty", 0, 17'h10000);
    check("empty_starts", 64'(start_cnt), 64'd1);
    check("empty_runs", 64'(runs.size()), 64'd1);
    check("empty_run_len", 64'(runs[0]), 64'(R));
    check("empty_start_latency", 64'(start_edge - acc_edge), 64'd2);
    check("empty_lane0_latency", 64'(lane0_edge - acc_edge), 64'd3);
    check("empty_idle_zero", 64'(idle_dirty), 64'd0);
    clear_cap();

    // "abc" with garbage above the valid bytes.
    msg = {64'hDEAD_BEEF_5563_6261};
    send_msg(3, 4'd8);
    wait_lanes("abc", R);
    set_pad_block();
    exp_lanes[0] = 64'h0000_0000_0663_6261;
    check_block("abc", 0, 17'h10000);
    check("abc_starts", 64'(start_cnt), 64'd1);
    clear_cap();

    // One full 8-byte last word: domain byte lands in lane 1.
    msg = {64'h0807_0605_0403_0201};
    send_msg(8, 4'd8);
    wait_lanes("w8", R);
    set_pad_block();
    exp_lanes[0] = 64'h0807_0605_0403_0201;
    exp_lanes[1] = 64'h06;
    check_block("w8", 0, 17'h10000);
    clear_cap();

    // 135 bytes: domain and end bit share byte 7 of lane 16; short in_bytes on non-last words ignored.
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(pat(i));
    msg.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    send_msg(7, 4'd3);
    wait_lanes("b135", R);
    for (int i = 0; i < 16; i++) exp_lanes[i] = pat(i);
    exp_lanes[16] = 64'h86FF_FFFF_FFFF_FFFF;
    check_block("b135", 0, 17'h10000);
    check("b135_starts", 64'(start_cnt), 64'd1);
    check("b135_run_len", 64'(runs[0]), 64'(R));
    clear_cap();

    // 136 bytes: full non-final block, then a pure padding block.
    msg.delete();
    for (int i = 0; i < 17; i++) msg.push_back(pat(i + 20));
    send_msg(8, 4'd12);
    wait_lanes("b136", 2 * R);
    for (int i = 0; i < R; i++) exp_lanes[i] = pat(i + 20);
    check_block("b136_blk0", 0, 17'h00000);
    set_pad_block();
    check_block("b136_blk1", R, 17'h10000);
    check("b136_starts", 64'(start_cnt), 64'd1);
    check("b136_runs", 64'(runs.size()), 64'd2);
    check("b136_run0", 64'(runs[0]), 64'(R));
    check("b136_run1", 64'(runs[1]), 64'(R));
    clear_cap();

    // Core not ready for 20 cycles: nothing leaves, input stays closed.
    bus.core_ready = 1'b0;
    msg = {64'h0000_0000_0063_6261};
    send_msg(3, 4'd8);
    begin
      int bad;
      bad = 0;
      repeat (20) begin
        tick();
        if (bus.out_valid || bus.out_start || bus.in_ready) bad++;
      end
      check("hold_quiet", 64'(bad), 64'd0);
    end
    bus.core_ready = 1'b1;
    wait_lanes("hold", R);
    set_pad_block();
    exp_lanes[0] = 64'h0000_0000_0663_6261;
    check_block("hold", 0, 17'h10000);
    check("hold_runs", 64'(runs.size()), 64'd1);
    check("hold_run_len", 64'(runs[0]), 64'(R));
    clear_cap();

    // Reset while lane 5 is on the output.
    msg = {64'd0};
    send_msg(0, 4'd8);
    begin
      int g;
      g = 0;
      while (cap_data.size() < 6 && g < 100) begin
        tick();
        g++;
      end
      check("mid_rst_reach_lane5", 64'(cap_data.size()), 64'd6);
    end
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_data", bus.out_data, 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_release_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) tick();
    clear_cap();
    repeat (5) tick();
    check("mid_rst_no_output", 64'(cap_data.size() + start_cnt), 64'd0);

    msg = {64'h0000_0000_0063_6261};
    send_msg(3, 4'd8);
    wait_lanes("fresh", R);
    set_pad_block();
    exp_lanes[0] = 64'h0000_0000_0663_6261;
    check_block("fresh", 0, 17'h10000);
    check("fresh_starts", 64'(start_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha3_pad_feeder.md
# sha3_pad_feeder

Upstream message formatter for the SHA3 core. Accepts a message as a stream of 64-bit little-endian words with a byte count on the final word. Applies SHA-3 pad10*1 with the domain suffix, buffers one full rate block, and replays it to the core's `start` / `data_in` / `last_block` inputs as back-to-back lanes whenever the core signals `ready`. The core cannot be stalled mid-block, so this block guarantees gap-free delivery of each block.

## Interface
- `RATE_LANES`, 17, 64-bit lanes per block (17 = SHA3-256); legal 9..21.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept an input word.
- `in_data`  in  64  message bytes, byte k at bits [8k+7:8k].
- `in_bytes`  in  4  valid bytes in `in_data`, 0..8; values below 8 are honoured only with `in_last`, otherwise treated as 8.
- `in_last`  in  1  final word of the message.
- `core_ready`  in  1  core can absorb a new block (core `ready`).
- `out_start`  out  1  one-cycle pulse before the first word of a message (core `start`).
- `out_valid`  out  1  `out_data` carries a lane this cycle.
- `out_data`  out  64  lane to core `data_in`.
- `out_last_block`  out  1  high with lane RATE_LANES-1 of the final block (core `last_block`).

## Operation
- States: FILL, WAIT_CORE, START, EMIT, PADBLK.
- FILL (`in_ready`=1): each accepted word is written to lane index `idx`, then `idx`++.
- Non-last word at `idx`=RATE_LANES-1: go to WAIT_CORE with block marked not-final.
- `in_last` with b=`in_bytes` < 8: byte b of that lane = 0x06, higher bytes 0.
- `in_last` with b = 8 and `idx` < RATE_LANES-1: next lane byte 0 = 0x06.
- In both `in_last` cases: all remaining lanes are 0, byte 7 of lane RATE_LANES-1 is ORed with 0x80 (0x06|0x80 = 0x86 when they coincide), and the block is marked final.
- `in_last`, 8 bytes, `idx`=RATE_LANES-1: the block is emitted non-final, then PADBLK builds a block with lane0=0x06, lane RATE_LANES-1=0x8000000000000000, all other lanes 0, and marks it final.
- WAIT_CORE: hold until `core_ready`=1. Then go to START if this is the first block of the message, else EMIT.
- START: `out_start`=1 for one cycle, then EMIT.
- EMIT: lanes 0..RATE_LANES-1 on consecutive cycles with `out_valid`=1. `out_last_block`=1 only on the last lane of a final block.
- After EMIT: next block of the same message, or PADBLK, or FILL with lanes cleared and the first-block flag set.
- `core_ready` is ignored outside WAIT_CORE.
- Outputs are registered. `out_data`=0 whenever `out_valid`=0.

## Timing
- Reset values: `in_ready`=0 during reset, 1 the cycle after; `out_start`, `out_valid`, `out_last_block` = 0; `out_data`=0; state FILL, `idx`=0, buffer cleared.
- Input handshake: transfer on edge with `in_valid`&`in_ready`. `in_ready`=0 in every state except FILL.
- Latency: block-completing word accepted at edge E gives WAIT_CORE at E+1. With `core_ready`=1 then: `out_start` at E+2 and lane0 at E+3 for the first block, or lane0 at E+2 for later blocks.
- Emission: exactly RATE_LANES consecutive `out_valid` cycles, never interrupted.
- PADBLK takes one cycle, then WAIT_CORE.
- `rst` in any state: discard the buffer and any partial message. No further output pulses after the reset edge.

## Configuration
- `SHA3_PAD_SHAKE_EN` defined: adds input `in_shake` (1 bit), sampled with the first word of a message. `in_shake`=1 makes the domain byte 0x1F instead of 0x06; the 0x80 OR rule is unchanged (0x9F when coincident).
- Not defined: the port is absent and the domain byte is always 0x06.

## Test plan
- Empty message (`in_last`, `in_bytes`=0): `out_start` pulse, then lane0=0x0000000000000006, lanes 1..15=0, lane16=0x8000000000000000 with `out_last_block`=1.
- "abc" (`in_data`=0x636261, `in_bytes`=3, `in_last`): lane0=0x0000000006636261, lane16=0x8000000000000000.
- 135 bytes (16 full words + 7-byte last word 0x..FF): lane16 byte 7 = 0x86; single block, `out_last_block` on lane 16 only.
- 136 bytes: first block non-final with no `out_last_block`; second block is pure padding (lane0=0x06, lane16=0x80<<56) with `out_last_block`=1; exactly one `out_start`.
- `core_ready` held low 20 cycles in WAIT_CORE: no output and `in_ready`=0. Raising it yields 17 contiguous lanes.
- `rst` asserted mid-EMIT at lane 5: outputs 0 the next cycle, `in_ready`=1 after release. A following "abc" message produces a correct fresh block.
